instr_fetch_unit: RTL

- Consumer side of the program-counter loop. Takes the registered PC (pc_in), fetches one instruction per request from instruction memory over a req/ack handshake, and presents it to the IF/ID stage with valid/ready.
- Computes next_pc, which feeds the PC register's input.
- Handles branch/jump redirects, including discarding a stale in-flight fetch.
- Only one memory request is outstanding at any time.

---
 rtl/instr_fetch_unit_pkg.sv | 23 ++
 rtl/instr_fetch_unit_if.sv | 31 +++
 rtl/instr_fetch_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared fetch constants and state type
// Holds bus widths, the sequential PC step, the reset fetch address
// and the fetch FSM state enumeration used by the interface and the top.
package instr_fetch_unit_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] PC_STEP  = 'd4;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    // IDLE : nothing outstanding, nothing presented
    // WAIT : request outstanding, response will be presented
    // HOLD : instruction presented to decode, waiting for id_ready
    // DRAIN: request outstanding but squashed by a redirect
    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_WAIT  = 2'd1,
        FS_HOLD  = 2'd2,
        FS_DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - fetch unit bus bundle
// Groups the PC loop (pc_in/next_pc), instruction memory req/ack port,
// redirect input and the IF/ID valid/ready output.
// master: the fetch unit. slave: PC register, memory, decode and redirect source.
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    logic [ADDR_W-1:0] pc_in;
    logic [ADDR_W-1:0] next_pc;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              if_valid;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              id_ready;

    modport master (
        input  pc_in, imem_ack, imem_rdata, redirect, redirect_pc, id_ready,
        output next_pc, imem_req, imem_addr, if_valid, if_instr, if_pc
    );

    modport slave (
        output pc_in, imem_ack, imem_rdata, redirect, redirect_pc, id_ready,
        input  next_pc, imem_req, imem_addr, if_valid, if_instr, if_pc
    );

endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - single-outstanding instruction fetch unit
// Ports:
//   clk   - clock, state updates on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - instr_fetch_unit_if.master: pc_in/next_pc PC loop, imem req/ack
//           memory port, redirect/redirect_pc, if_valid/if_instr/if_pc/id_ready
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic              r_imem_req;
    logic [ADDR_W-1:0] r_imem_addr;
    logic              r_if_valid;
    logic [DATA_W-1:0] r_if_instr;
    logic [ADDR_W-1:0] r_if_pc;
    logic              w_advance;
    logic              w_load_req;
    logic              w_load_out;
    logic [ADDR_W-1:0] w_next_pc;

    // A response only counts as an advance when it belongs to a live fetch;
    // an ack in DRAIN is the squashed request and leaves the PC alone.
    assign w_advance = (r_state == FS_WAIT) && bus.imem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FS_IDLE: begin
                if (!bus.redirect) w_state_nxt = FS_WAIT;
            end
            FS_WAIT: begin
                if (bus.redirect)      w_state_nxt = bus.imem_ack ? FS_IDLE : FS_DRAIN;
                else if (bus.imem_ack) w_state_nxt = FS_HOLD;
            end
            FS_HOLD: begin
                if (bus.redirect)      w_state_nxt = FS_IDLE;
                else if (bus.id_ready) w_state_nxt = FS_WAIT;
            end
            FS_DRAIN: begin
                // The pending response must still be swallowed, so an ack
                // always ends the drain even if another redirect arrives.
                if (bus.imem_ack) w_state_nxt = FS_IDLE;
            end
            default: w_state_nxt = FS_IDLE;
        endcase
    end

    always_comb begin
        w_load_req = ((r_state == FS_IDLE) || (r_state == FS_HOLD)) && (w_state_nxt == FS_WAIT);
        w_load_out = w_advance && !bus.redirect;
        if (bus.redirect)   w_next_pc = bus.redirect_pc;
        else if (w_advance) w_next_pc = bus.pc_in + PC_STEP;
        else                w_next_pc = bus.pc_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imem_req  <= 1'b0;
            r_imem_addr <= RESET_PC;
            r_if_valid  <= 1'b0;
            r_if_instr  <= '0;
            r_if_pc     <= '0;
        end else begin
            r_imem_req <= (w_state_nxt == FS_WAIT) || (w_state_nxt == FS_DRAIN);
            r_if_valid <= (w_state_nxt == FS_HOLD);
            if (w_load_req) r_imem_addr <= bus.pc_in;
            if (w_load_out) begin
                r_if_instr <= bus.imem_rdata;
                r_if_pc    <= r_imem_addr;
            end
        end
    end

    assign bus.next_pc   = w_next_pc;
    assign bus.imem_req  = r_imem_req;
    assign bus.imem_addr = r_imem_addr;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_instr  = r_if_instr;
    assign bus.if_pc     = r_if_pc;

endmodule
